ws2812_bit_decoder: RTL and testbench

Downstream consumer of the pipeline edge-timing counter. Samples the counter at each line edge to measure WS2812 high-pulse widths, classifies each pulse as a 0 or 1 bit, and assembles 24-bit GRB pixel words. Detects the inter-frame reset gap and flags malformed pulses. Presents completed pixels on a one-entry valid/ready output buffer to the pixel/PWM stage.

---
 rtl/ws2812_bit_decoder_pkg.sv | 41 ++++
 rtl/ws2812_bit_decoder.sv | 178 +++++++++++++++++
 tb/tb_ws2812_bit_decoder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_bit_decoder_pkg.sv
// Shared types and defaults for the WS2812 edge-timing pipeline.
// The decoder imports the state enum, pixel structs and pulse-width thresholds from here.
package ws2812_bit_decoder_pkg;

  typedef struct packed {
    logic rising;
    logic falling;
  } control_path_t;

  typedef struct packed {
    logic [9:0] counter;
  } decoder_input_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_ERROR = 2'd3
  } decoder_state_e;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  typedef struct packed {
    pixel_t     pixel;
    logic [7:0] index;
    logic       valid;
  } decoder_output_t;

  localparam logic [9:0] DEF_MIN_HIGH      = 10'd4;
  localparam logic [9:0] DEF_BIT_THRESHOLD = 10'd12;
  localparam logic [9:0] DEF_MAX_HIGH      = 10'd24;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ws2812_bit_decoder.sv
// Measures WS2812 high-pulse widths from the edge-timing counter and assembles GRB words.
// Completed pixels sit in a one-entry valid/ready buffer; the reset gap ends a frame.
module ws2812_bit_decoder
  import ws2812_bit_decoder_pkg::*;
#(
  parameter logic [9:0] P_MIN_HIGH      = DEF_MIN_HIGH,
  parameter logic [9:0] P_BIT_THRESHOLD = DEF_BIT_THRESHOLD,
  parameter logic [9:0] P_MAX_HIGH      = DEF_MAX_HIGH
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  control_path_t  i_control,
  input  decoder_input_t i_decoder_input,
  input  logic           i_ready,
  output logic [23:0]    o_pixel,
  output logic           o_valid,
  output logic [7:0]     o_pixel_index,
  output logic           o_frame_done,
  output logic           o_error
);

  decoder_state_e  state_q, state_d;
  logic [23:0]     shift_q, shift_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      frame_idx_q, frame_idx_d;
  decoder_output_t out_q, out_d;
  logic            frame_done_q, frame_done_d;
  logic            error_q, error_d;
  logic            line_hi_q, line_hi_d;

  logic        rise_s, fall_s, both_s, sat_s;
  logic        shift_en_s, shift_bit_s, frame_rst_s;
  logic [23:0] word_s;

  // Next-state, shift register and output buffer logic
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    frame_idx_d  = frame_idx_q;
    out_d        = out_q;
    out_d.valid  = out_q.valid & ~i_ready;
    frame_done_d = 1'b0;
    error_d      = error_q;
    shift_en_s   = 1'b0;
    frame_rst_s  = 1'b0;
    rise_s       = i_control.rising;
    fall_s       = i_control.falling;
    both_s       = rise_s & fall_s;
    sat_s        = i_decoder_input.counter[9];
    shift_bit_s  = (i_decoder_input.counter >= P_BIT_THRESHOLD);
    word_s       = {shift_q[22:0], shift_bit_s};

    if (rise_s && !fall_s) begin
      line_hi_d = 1'b1;
    end else if (fall_s && !rise_s) begin
      line_hi_d = 1'b0;
    end else begin
      line_hi_d = line_hi_q;
    end

    case (state_q)
      S_IDLE: begin
        if (both_s) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else if (rise_s) begin
          state_d = S_HIGH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HIGH: begin
        if (both_s) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else if (fall_s) begin
          if ((i_decoder_input.counter < P_MIN_HIGH) || (i_decoder_input.counter > P_MAX_HIGH)) begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end else begin
            shift_en_s = 1'b1;
            state_d    = S_LOW;
          end
        end else if (sat_s) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else begin
          state_d = S_HIGH;
        end
      end
      S_LOW: begin
        if (both_s) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else if (rise_s) begin
          state_d = S_HIGH;
        end else if (sat_s) begin
          frame_rst_s = 1'b1;
        end else begin
          state_d = S_LOW;
        end
      end
      S_ERROR: begin
        // Only a saturated low phase ends the error; a stuck-high line keeps waiting
        if (sat_s && !line_hi_q && !rise_s && !fall_s) begin
          frame_rst_s = 1'b1;
        end else begin
          state_d = S_ERROR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (shift_en_s) begin
      shift_d = word_s;
      if (bit_cnt_q == 5'd23) begin
        bit_cnt_d   = 5'd0;
        frame_idx_d = sat_inc8(frame_idx_q);
        if (out_q.valid && !i_ready) begin
          error_d = 1'b1;
        end else begin
          out_d.pixel = word_s;
          out_d.index = frame_idx_q;
          out_d.valid = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end else begin
      shift_d = shift_q;
    end

    if (frame_rst_s) begin
      frame_done_d = 1'b1;
      shift_d      = 24'd0;
      bit_cnt_d    = 5'd0;
      frame_idx_d  = 8'd0;
      out_d.index  = 8'd0;
      error_d      = 1'b0;
      state_d      = S_IDLE;
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      shift_q      <= 24'd0;
      bit_cnt_q    <= 5'd0;
      frame_idx_q  <= 8'd0;
      out_q        <= '0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      line_hi_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_idx_q  <= frame_idx_d;
      out_q        <= out_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
      line_hi_q    <= line_hi_d;
    end
  end

  assign o_pixel       = out_q.pixel;
  assign o_valid       = out_q.valid;
  assign o_pixel_index = out_q.index;
  assign o_frame_done  = frame_done_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_ws2812_bit_decoder.sv
// Scoreboard bench for ws2812_bit_decoder: directed pulse trains, expected pixels queued at issue
// and checked by a monitor on every valid/ready transfer.
module tb_ws2812_bit_decoder;
  import ws2812_bit_decoder_pkg::*;

  logic           i_clk = 1'b0;
  logic           i_reset_n = 1'b0;
  control_path_t  i_control = '0;
  decoder_input_t i_decoder_input = '0;
  logic           i_ready = 1'b1;
  logic [23:0]    o_pixel;
  logic           o_valid;
  logic [7:0]     o_pixel_index;
  logic           o_frame_done;
  logic           o_error;

  typedef struct {
    logic [23:0] pixel;
    logic [7:0]  index;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   fd_cnt = 0;
  int   fd_base;

  ws2812_bit_decoder dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_control       (i_control),
    .i_decoder_input (i_decoder_input),
    .i_ready         (i_ready),
    .o_pixel         (o_pixel),
    .o_valid         (o_valid),
    .o_pixel_index   (o_pixel_index),
    .o_frame_done    (o_frame_done),
    .o_error         (o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: compare every transferred pixel against the scoreboard
  always @(negedge i_clk) begin
    if (i_reset_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pixel: got %h idx %0d required no transfer", o_pixel, o_pixel_index);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pixel", {8'd0, o_pixel}, {8'd0, e.pixel});
        check("pixel_index", {24'd0, o_pixel_index}, {24'd0, e.index});
      end
    end
    if (o_frame_done) fd_cnt++;
  end

  task automatic cyc(input logic r, input logic f, input logic [9:0] cnt);
    i_control.rising        = r;
    i_control.falling       = f;
    i_decoder_input.counter = cnt;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic [9:0] h);
    cyc(1'b1, 1'b0, 10'd8);
    cyc(1'b0, 1'b0, 10'd0);
    cyc(1'b0, 1'b0, 10'd1);
    cyc(1'b0, 1'b1, h);
    cyc(1'b0, 1'b0, 10'd0);
    cyc(1'b0, 1'b0, 10'd1);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i] ? 10'd16 : 10'd8);
  endtask

  task automatic gap();
    repeat (5) cyc(1'b0, 1'b0, 10'd512);
    cyc(1'b0, 1'b0, 10'd0);
  endtask

  task automatic push(input logic [23:0] p, input logic [7:0] idx);
    exp_t e;
    e.pixel = p;
    e.index = idx;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [9:0]  wtab [4];
    logic [19:0] tail;
    wtab = '{10'd4, 10'd11, 10'd12, 10'd24};
    tail = 20'h5A5A5;

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_pixel", {8'd0, o_pixel}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_index", {24'd0, o_pixel_index}, 32'd0);
    check("rst_frame_done", {31'd0, o_frame_done}, 32'd0);
    check("rst_error", {31'd0, o_error}, 32'd0);
    i_reset_n = 1'b1;
    cyc(1'b0, 1'b0, 10'd0);

    // Single word
    push(24'hA5C3F0, 8'd0);
    send_word(24'hA5C3F0);
    fd_base = fd_cnt;
    gap();
    check("frame_done_once_1", fd_cnt - fd_base, 32'd1);
    check("error_clean_1", {31'd0, o_error}, 32'd0);

    // Back-to-back words
    push(24'h000000, 8'd0);
    push(24'hFFFFFF, 8'd1);
    send_word(24'h000000);
    send_word(24'hFFFFFF);
    fd_base = fd_cnt;
    gap();
    check("frame_done_once_2", fd_cnt - fd_base, 32'd1);
    check("error_clean_2", {31'd0, o_error}, 32'd0);

    // Width below minimum
    send_bit(10'd3);
    check("err_width3", {31'd0, o_error}, 32'd1);
    check("state_err_width3", {30'd0, dut.state_q}, {30'd0, S_ERROR});
    fd_base = fd_cnt;
    gap();
    check("err_cleared_3", {31'd0, o_error}, 32'd0);
    check("frame_done_err_3", fd_cnt - fd_base, 32'd1);

    // Width above maximum
    send_bit(10'd25);
    check("err_width25", {31'd0, o_error}, 32'd1);
    check("state_err_width25", {30'd0, dut.state_q}, {30'd0, S_ERROR});
    gap();
    check("err_cleared_25", {31'd0, o_error}, 32'd0);

    // Threshold edges 4,11 -> 0 and 12,24 -> 1, then a 20-bit tail
    push(24'h35A5A5, 8'd0);
    for (int i = 0; i < 4; i++) send_bit(wtab[i]);
    for (int i = 19; i >= 0; i--) send_bit(tail[i] ? 10'd16 : 10'd8);
    check("err_boundary_word", {31'd0, o_error}, 32'd0);
    gap();

    // Partial word discarded by frame reset
    for (int i = 0; i < 10; i++) send_bit(10'd16);
    gap();
    check("bit_cnt_cleared", {27'd0, dut.bit_cnt_q}, 32'd0);
    push(24'h123456, 8'd0);
    send_word(24'h123456);
    gap();

    // Output overflow with i_ready low
    i_ready = 1'b0;
    push(24'hC0FFEE, 8'd0);
    send_word(24'hC0FFEE);
    send_word(24'h00BEEF);
    check("overflow_error", {31'd0, o_error}, 32'd1);
    check("overflow_valid", {31'd0, o_valid}, 32'd1);
    check("overflow_keeps_old", {8'd0, o_pixel}, 32'h00C0FFEE);
    i_ready = 1'b1;
    cyc(1'b0, 1'b0, 10'd1);
    check("valid_dropped", {31'd0, o_valid}, 32'd0);
    gap();

    // Asynchronous reset mid-word
    for (int i = 0; i < 10; i++) send_bit(10'd16);
    #2 i_reset_n = 1'b0;
    #1;
    check("arst_pixel", {8'd0, o_pixel}, 32'd0);
    check("arst_valid", {31'd0, o_valid}, 32'd0);
    check("arst_index", {24'd0, o_pixel_index}, 32'd0);
    check("arst_error", {31'd0, o_error}, 32'd0);
    check("arst_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    cyc(1'b0, 1'b0, 10'd0);
    push(24'hABCDEF, 8'd0);
    send_word(24'hABCDEF);
    gap();

    repeat (4) cyc(1'b0, 1'b0, 10'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
